// File: rtl/controle_processador.sv
// Multicycle control unit for the 8-register bus processor: fetches III XXX YYY
// instructions and sequences the datapath enables over steps T0..T3.
module controle_processador #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OP_W  = 3
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        Run,
   input  logic [OP_W+2*SEL_W-1:0]     DIN,
   output logic                        IRin,
   output logic [(2**SEL_W)-1:0]       Rin,
   output logic [(2**SEL_W)-1:0]       Rout,
   output logic                        DINout,
   output logic                        Gout,
   output logic                        Ain,
   output logic                        Gin,
   output logic                        AddSub,
   output logic                        Done
);

   localparam int unsigned REG_N = 2**SEL_W;
   localparam int unsigned IR_W  = OP_W + 2*SEL_W;

   localparam logic [OP_W-1:0] OP_MV  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_MVI = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);

   typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

   step_t             state, next_state;
   logic [IR_W-1:0]   ir;
   logic [OP_W-1:0]   op;
   logic [SEL_W-1:0]  rx, ry;

   assign op = ir[IR_W-1 -: OP_W];
   assign rx = ir[2*SEL_W-1 -: SEL_W];
   assign ry = ir[SEL_W-1:0];

   // Same 3->8 one-hot decode as the register-file decoder
   function automatic logic [REG_N-1:0] dec(input logic [SEL_W-1:0] n);
      return REG_N'(1) << n;
   endfunction

   // Step counter and instruction register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= T0;
         ir    <= '0;
      end else begin
         state <= next_state;
         if (state == T0 && Run)
            ir <= DIN;
      end
   end

   // Next step and datapath enables; Reset forces every output low
   always_comb begin
      next_state = state;
      IRin       = 1'b0;
      Rin        = '0;
      Rout       = '0;
      DINout     = 1'b0;
      Gout       = 1'b0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      AddSub     = 1'b0;
      Done       = 1'b0;

      case (state)
         T0: begin
            if (Run) begin
               IRin       = 1'b1;
               next_state = T1;
            end
         end
         T1: begin
            next_state = T0;
            case (op)
               OP_MV: begin
                  Rout = dec(ry);
                  Rin  = dec(rx);
                  Done = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  Rin    = dec(rx);
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  Rout       = dec(rx);
                  Ain        = 1'b1;
                  next_state = T2;
               end
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            Rout       = dec(ry);
            Gin        = 1'b1;
            AddSub     = (op == OP_SUB);
            next_state = T3;
         end
         T3: begin
            Gout       = 1'b1;
            Rin        = dec(rx);
            Done       = 1'b1;
            next_state = T0;
         end
         default: next_state = T0;
      endcase

      if (Reset) begin
         IRin   = 1'b0;
         Rin    = '0;
         Rout   = '0;
         DINout = 1'b0;
         Gout   = 1'b0;
         Ain    = 1'b0;
         Gin    = 1'b0;
         AddSub = 1'b0;
         Done   = 1'b0;
      end
   end

endmodule

// File: tb/tb_controle_processador.sv
// Directed bench for controle_processador: per-step output vectors for
// mv, mvi, add, sub, NOP, reset abort and back-to-back execution.
module tb_controle_processador;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Run   = 1'b0;
   logic [8:0] DIN   = '0;
   logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
   logic [7:0] Rin, Rout;

   int checks   = 0;
   int failures = 0;

   controle_processador dut (
      .Clock (Clock), .Reset (Reset), .Run (Run), .DIN (DIN),
      .IRin (IRin), .Rin (Rin), .Rout (Rout), .DINout (DINout),
      .Gout (Gout), .Ain (Ain), .Gin (Gin), .AddSub (AddSub), .Done (Done)
   );

   always #5 Clock = ~Clock;

   logic [22:0] obs;
   assign obs = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};

   // Expected output vector in the same field order as obs
   function automatic logic [22:0] e(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic dinout,
                                     input logic gout, input logic ain,
                                     input logic gin, input logic addsub,
                                     input logic done);
      return {irin, rin, rout, dinout, gout, ain, gin, addsub, done};
   endfunction

   // Bus-driver exclusivity and one-hot enables, every cycle
   always @(negedge Clock) begin
      checks++;
      if ((int'(Rout != 8'h00) + int'(Gout) + int'(DINout)) > 1 ||
          !$onehot0(Rin) || !$onehot0(Rout)) begin
         failures++;
         $display("FAIL invariant t=%0t Rin=%h Rout=%h Gout=%b DINout=%b",
                  $time, Rin, Rout, Gout, DINout);
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Run = 1'b1; DIN = 9'b001_010_000;
      for (int i = 0; i < 2; i++) begin
         tick();
         @(negedge Clock);
         checks++;
         if (obs !== 23'h0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, 23'h0);
         end
      end
      tick();
      Reset = 1'b0; Run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== 23'h0) begin
            failures++;
            $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs, 23'h0);
         end
         tick();
      end
   endtask

   task automatic test_mvi();
      logic [22:0] exp_v [3];
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1);
      exp_v[2] = 23'h0;
      Run = 1'b1; DIN = 9'b001_010_000;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL mvi step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         Run = 1'b0; DIN = 9'h0ab;
      end
   endtask

   task automatic test_mv();
      logic [22:0] exp_v [3];
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h02, 8'h20, 0, 0, 0, 0, 0, 1);
      exp_v[2] = 23'h0;
      Run = 1'b1; DIN = 9'b000_001_101;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL mv step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         DIN = 9'b011_111_111;
         if (i == 0) Run = 1'b0;
      end
   endtask

   task automatic test_sub();
      logic [22:0] exp_v [5];
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0);
      exp_v[2] = e(0, 8'h00, 8'h40, 0, 0, 0, 1, 1, 0);
      exp_v[3] = e(0, 8'h08, 8'h00, 0, 1, 0, 0, 0, 1);
      exp_v[4] = 23'h0;
      Run = 1'b1; DIN = 9'b011_011_110;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL sub step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         DIN = 9'b000_000_000;
         if (i == 2) Run = 1'b0;
         else if (i < 2) Run = 1'b1;
      end
   endtask

   task automatic test_add_reset();
      logic [22:0] exp_v [5];
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0);
      exp_v[2] = 23'h0;
      exp_v[3] = 23'h0;
      exp_v[4] = 23'h0;
      Run = 1'b1; DIN = 9'b010_000_111;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL add_reset step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         Run = 1'b0;
         Reset = (i == 1);
      end
      Run = 1'b1; DIN = 9'b000_010_010;
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h04, 8'h04, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL mv_same step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         Run = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [22:0] exp_v [7];
      exp_v[0] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[1] = e(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
      exp_v[2] = e(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      exp_v[3] = e(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0);
      exp_v[4] = e(0, 8'h00, 8'h02, 0, 0, 0, 1, 0, 0);
      exp_v[5] = e(0, 8'h01, 8'h00, 0, 1, 0, 0, 0, 1);
      exp_v[6] = 23'h0;
      Run = 1'b1; DIN = 9'b111_000_000;
      for (int i = 0; i < 7; i++) begin
         @(negedge Clock);
         checks++;
         if (obs !== exp_v[i]) begin
            failures++;
            $display("FAIL b2b step=%0d got=%h exp=%h", i, obs, exp_v[i]);
         end
         tick();
         if (i == 0) DIN = 9'b010_000_001;
         if (i == 2) DIN = 9'b011_111_111;
         if (i == 5) Run = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_mv();
      test_sub();
      test_add_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
